// File: rtl/control_sequencer_if.sv
// Control bus between the hardwired sequencer (master) and the ALU datapath
// system (slave): every select/enable the datapath consumes, plus the IR
// contents and Z flag read back by the sequencer.
interface control_sequencer_if #(
  parameter int unsigned T_WIDTH = 3
);
  // Readback from the datapath
  logic [15:0]        IROut;
  logic               Z;

  // Register file
  logic [2:0]         RF_OutASel;
  logic [2:0]         RF_OutBSel;
  logic [2:0]         RF_FunSel;
  logic [3:0]         RF_RegSel;
  logic [3:0]         RF_ScrSel;

  // ALU
  logic [4:0]         ALU_FunSel;
  logic               ALU_WF;

  // Address register file
  logic [1:0]         ARF_OutCSel;
  logic [1:0]         ARF_OutDSel;
  logic [2:0]         ARF_FunSel;
  logic [2:0]         ARF_RegSel;

  // Instruction register and memory
  logic               IR_LH;
  logic               IR_Write;
  logic               Mem_WR;
  logic               Mem_CS;

  // Datapath multiplexers
  logic [1:0]         MuxASel;
  logic [1:0]         MuxBSel;
  logic               MuxCSel;

  // Sequencer status
  logic [T_WIDTH-1:0] T;
  logic               Halted;

  modport master (
    input  IROut, Z,
    output RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel,
           ALU_FunSel, ALU_WF,
           ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
           IR_LH, IR_Write, Mem_WR, Mem_CS,
           MuxASel, MuxBSel, MuxCSel,
           T, Halted
  );

  modport slave (
    output IROut, Z,
    input  RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel,
           ALU_FunSel, ALU_WF,
           ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
           IR_LH, IR_Write, Mem_WR, Mem_CS,
           MuxASel, MuxBSel, MuxCSel,
           T, Halted
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired control sequencer for the ALU datapath system.
// Fetches a 16-bit instruction as two byte reads into IR (T=0 low, T=1 high),
// then issues a single execute micro-cycle (T=2). HALT_OPCODE parks the
// sequencer until Reset. Outputs are a combinational decode of state, T,
// IROut and Z; the default word is driven whenever nothing else applies.
// Optional macro SEQ_STALL_EN adds a Stall input that freezes state and T
// and forces the default word while high.
module control_sequencer #(
  parameter logic [5:0]  HALT_OPCODE = 6'h3F,
  parameter int unsigned T_WIDTH     = 3
) (
  input  logic                 Clock,
  input  logic                 Reset,
`ifdef SEQ_STALL_EN
  input  logic                 Stall,
`endif
  control_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  // Opcodes handled explicitly in EXEC
  localparam logic [5:0] OP_BRA = 6'h00;
  localparam logic [5:0] OP_BNE = 6'h01;
  localparam logic [5:0] OP_INC = 6'h02;
  localparam logic [5:0] OP_LDI = 6'h03;
  localparam logic [5:0] OP_LD  = 6'h04;
  localparam logic [5:0] OP_ST  = 6'h05;

  // Function / select encodings
  localparam logic [2:0] FUN_INC  = 3'b001;
  localparam logic [2:0] FUN_LOAD = 3'b010;
  localparam logic [2:0] FUN_CLR  = 3'b011;
  localparam logic [4:0] ALU_PASS_A = 5'b10000;
  localparam logic [1:0] OUTD_PC  = 2'b00;
  localparam logic [1:0] OUTD_AR  = 2'b10;
  localparam logic [2:0] ARF_PC   = 3'b100;
  localparam logic [2:0] ARF_ALL  = 3'b111;

  localparam logic [T_WIDTH-1:0] T_LOW  = T_WIDTH'(0);
  localparam logic [T_WIDTH-1:0] T_HIGH = T_WIDTH'(1);
  localparam logic [T_WIDTH-1:0] T_EXEC = T_WIDTH'(2);

  state_t               r_state;
  logic [T_WIDTH-1:0]   r_t;

  state_t               w_state_nxt;
  logic [T_WIDTH-1:0]   w_t_nxt;
  logic                 w_stall;
  logic [5:0]           w_opcode;
  logic [1:0]           w_rsel;
  logic [3:0]           w_rx_onehot;
  logic                 w_fetch_step;

`ifdef SEQ_STALL_EN
  assign w_stall = Stall;
`else
  assign w_stall = 1'b0;
`endif

  assign w_opcode     = bus.IROut[15:10];
  assign w_rsel       = bus.IROut[9:8];
  // Rsel 0 selects R1, which sits in bit 3 of the register enables
  assign w_rx_onehot  = 4'b1000 >> w_rsel;
  assign w_fetch_step = (r_t == T_LOW) || (r_t == T_HIGH);

  assign bus.T      = r_t;
  assign bus.Halted = (r_state == S_HALT);

  // State and timing-step registers; reset wins over everything
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state <= S_INIT;
      r_t     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_t     <= w_t_nxt;
    end
  end

  // Next-state and next-T; stall holds both
  always_comb begin
    w_state_nxt = r_state;
    w_t_nxt     = r_t;
    if (!w_stall) begin
      case (r_state)
        S_INIT: begin
          w_state_nxt = S_FETCH;
          w_t_nxt     = T_LOW;
        end
        S_FETCH: begin
          if (r_t == T_LOW) begin
            w_t_nxt = T_HIGH;
          end else if (r_t == T_HIGH) begin
            w_state_nxt = S_EXEC;
            w_t_nxt     = T_EXEC;
          end else begin
            // Unreachable T values recover to the start of a fetch
            w_state_nxt = S_FETCH;
            w_t_nxt     = T_LOW;
          end
        end
        S_EXEC: begin
          if (w_opcode == HALT_OPCODE) begin
            w_state_nxt = S_HALT;
          end else begin
            w_state_nxt = S_FETCH;
          end
          w_t_nxt = T_LOW;
        end
        S_HALT: begin
          w_state_nxt = S_HALT;
          w_t_nxt     = T_LOW;
        end
        default: begin
          w_state_nxt = S_FETCH;
          w_t_nxt     = T_LOW;
        end
      endcase
    end
  end

  // Control word decode; default word first, Reset low or Stall keeps it
  always_comb begin
    bus.RF_OutASel  = '0;
    bus.RF_OutBSel  = '0;
    bus.RF_FunSel   = '0;
    bus.RF_RegSel   = '0;
    bus.RF_ScrSel   = '0;
    bus.ALU_FunSel  = '0;
    bus.ALU_WF      = 1'b0;
    bus.ARF_OutCSel = '0;
    bus.ARF_OutDSel = '0;
    bus.ARF_FunSel  = '0;
    bus.ARF_RegSel  = '0;
    bus.IR_LH       = 1'b0;
    bus.IR_Write    = 1'b0;
    bus.Mem_WR      = 1'b0;
    bus.Mem_CS      = 1'b1;
    bus.MuxASel     = '0;
    bus.MuxBSel     = '0;
    bus.MuxCSel     = 1'b0;

    if (Reset && !w_stall) begin
      case (r_state)
        S_INIT: begin
          bus.ARF_FunSel = FUN_CLR;
          bus.ARF_RegSel = ARF_ALL;
        end
        S_FETCH: begin
          if (w_fetch_step) begin
            bus.ARF_OutDSel = OUTD_PC;
            bus.Mem_CS      = 1'b0;
            bus.IR_Write    = 1'b1;
            bus.IR_LH       = (r_t == T_HIGH);
            bus.ARF_RegSel  = ARF_PC;
            bus.ARF_FunSel  = FUN_INC;
          end
        end
        S_EXEC: begin
          // HALT_OPCODE is tested first so an override onto a real opcode
          // still parks the sequencer with the default word
          if (w_opcode != HALT_OPCODE) begin
            case (w_opcode)
              OP_BRA: begin
                bus.MuxBSel    = 2'b11;
                bus.ARF_FunSel = FUN_LOAD;
                bus.ARF_RegSel = ARF_PC;
              end
              OP_BNE: begin
                if (!bus.Z) begin
                  bus.MuxBSel    = 2'b11;
                  bus.ARF_FunSel = FUN_LOAD;
                  bus.ARF_RegSel = ARF_PC;
                end
              end
              OP_INC: begin
                bus.RF_FunSel = FUN_INC;
                bus.RF_RegSel = w_rx_onehot;
              end
              OP_LDI: begin
                bus.MuxASel   = 2'b11;
                bus.RF_FunSel = FUN_LOAD;
                bus.RF_RegSel = w_rx_onehot;
              end
              OP_LD: begin
                bus.ARF_OutDSel = OUTD_AR;
                bus.Mem_CS      = 1'b0;
                bus.MuxASel     = 2'b10;
                bus.RF_FunSel   = FUN_LOAD;
                bus.RF_RegSel   = w_rx_onehot;
              end
              OP_ST: begin
                bus.RF_OutASel  = {1'b0, w_rsel};
                bus.ALU_FunSel  = ALU_PASS_A;
                bus.MuxCSel     = 1'b0;
                bus.ARF_OutDSel = OUTD_AR;
                bus.Mem_CS      = 1'b0;
                bus.Mem_WR      = 1'b1;
              end
              default: begin
              end
            endcase
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed steps from the test
// plan followed by randomized instructions, each cycle compared against a
// behavioural model that tracks the instruction phase and builds the
// expected control word from the instruction-level rules.
module tb_control_sequencer;

  typedef struct packed {
    logic [2:0] oa;
    logic [2:0] ob;
    logic [2:0] rf_fun;
    logic [3:0] rf_reg;
    logic [3:0] scr;
    logic [4:0] alu_fun;
    logic       alu_wf;
    logic [1:0] oc;
    logic [1:0] od;
    logic [2:0] arf_fun;
    logic [2:0] arf_reg;
    logic       ir_lh;
    logic       ir_w;
    logic       mem_wr;
    logic       mem_cs;
    logic [1:0] ma;
    logic [1:0] mb;
    logic       mc;
    logic [2:0] t;
    logic       halted;
  } word_t;

  // Model phases: which cycle of the instruction life we are in
  localparam int PH_INIT = 0;
  localparam int PH_LOW  = 1;
  localparam int PH_HIGH = 2;
  localparam int PH_EXE  = 3;
  localparam int PH_HALT = 4;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  logic Stall = 1'b0;

  int total = 0;
  int bad   = 0;
  int phase = PH_INIT;

  always #5 Clock = ~Clock;

  control_sequencer_if #(.T_WIDTH(3)) bus ();

  control_sequencer #(
    .HALT_OPCODE (6'h3F),
    .T_WIDTH     (3)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
`ifdef SEQ_STALL_EN
    .Stall (Stall),
`endif
    .bus   (bus)
  );

  function automatic word_t dut_word();
    word_t w;
    w.oa      = bus.RF_OutASel;
    w.ob      = bus.RF_OutBSel;
    w.rf_fun  = bus.RF_FunSel;
    w.rf_reg  = bus.RF_RegSel;
    w.scr     = bus.RF_ScrSel;
    w.alu_fun = bus.ALU_FunSel;
    w.alu_wf  = bus.ALU_WF;
    w.oc      = bus.ARF_OutCSel;
    w.od      = bus.ARF_OutDSel;
    w.arf_fun = bus.ARF_FunSel;
    w.arf_reg = bus.ARF_RegSel;
    w.ir_lh   = bus.IR_LH;
    w.ir_w    = bus.IR_Write;
    w.mem_wr  = bus.Mem_WR;
    w.mem_cs  = bus.Mem_CS;
    w.ma      = bus.MuxASel;
    w.mb      = bus.MuxBSel;
    w.mc      = bus.MuxCSel;
    w.t       = bus.T;
    w.halted  = bus.Halted;
    return w;
  endfunction

  // Expected control word from the phase and the instruction-level rules
  function automatic word_t model_word(int ph, logic rst_n, logic stall,
                                       logic [15:0] ir, logic z);
    word_t w;
    int    op;
    int    rs;
    w        = '0;
    w.mem_cs = 1'b1;
    w.t      = (ph == PH_HIGH) ? 3'd1 : (ph == PH_EXE) ? 3'd2 : 3'd0;
    w.halted = (ph == PH_HALT);
    op = int'(ir) / 1024;
    rs = (int'(ir) / 256) % 4;
    if (!rst_n || stall) return w;
    if (ph == PH_INIT) begin
      w.arf_fun = 3'd3;
      w.arf_reg = 3'd7;
    end else if (ph == PH_LOW || ph == PH_HIGH) begin
      w.mem_cs  = 1'b0;
      w.ir_w    = 1'b1;
      w.ir_lh   = (ph == PH_HIGH);
      w.arf_reg = 3'd4;
      w.arf_fun = 3'd1;
    end else if (ph == PH_EXE) begin
      if (op == 0 || (op == 1 && z == 1'b0)) begin
        w.mb = 2'd3; w.arf_fun = 3'd2; w.arf_reg = 3'd4;
      end else if (op == 2) begin
        w.rf_fun = 3'd1; w.rf_reg = 4'(8 >> rs);
      end else if (op == 3) begin
        w.ma = 2'd3; w.rf_fun = 3'd2; w.rf_reg = 4'(8 >> rs);
      end else if (op == 4) begin
        w.od = 2'd2; w.mem_cs = 1'b0; w.ma = 2'd2;
        w.rf_fun = 3'd2; w.rf_reg = 4'(8 >> rs);
      end else if (op == 5) begin
        w.oa = 3'(rs); w.alu_fun = 5'd16; w.od = 2'd2;
        w.mem_cs = 1'b0; w.mem_wr = 1'b1;
      end
    end
    return w;
  endfunction

  // Check the current cycle mid-period, then advance the model at the edge
  task automatic cyc(input string tag);
    word_t got;
    word_t exp;
    @(negedge Clock);
    got = dut_word();
    exp = model_word(phase, Reset, Stall, bus.IROut, bus.Z);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h phase=%0d ir=%h", tag, got, exp, phase, bus.IROut);
    end
    @(posedge Clock);
    if (!Reset)                phase = PH_INIT;
    else if (Stall)            phase = phase;
    else if (phase == PH_INIT) phase = PH_LOW;
    else if (phase == PH_LOW)  phase = PH_HIGH;
    else if (phase == PH_HIGH) phase = PH_EXE;
    else if (phase == PH_EXE)  phase = (bus.IROut[15:10] == 6'h3F) ? PH_HALT : PH_LOW;
    #1;
  endtask

  initial begin
    logic [5:0] ops [8];
    ops[0] = 6'h00; ops[1] = 6'h01; ops[2] = 6'h02; ops[3] = 6'h03;
    ops[4] = 6'h04; ops[5] = 6'h05; ops[6] = 6'h3F; ops[7] = 6'h2A;

    bus.IROut = 16'h0000;
    bus.Z     = 1'b0;
    Reset     = 1'b0;
    Stall     = 1'b0;

    // Reset held for two cycles, then one INIT cycle and a fetch
    cyc("rst0");
    cyc("rst1");
    Reset = 1'b1;
    cyc("init");
    cyc("fetch_lo");
    cyc("fetch_hi");
    bus.IROut = 16'h0D42;
    cyc("ldi_r2");
    cyc("after_ldi_t0");
    cyc("t1");

    bus.IROut = 16'h0400; bus.Z = 1'b1;
    cyc("bne_z1");
    cyc("t0"); cyc("t1");
    bus.Z = 1'b0;
    cyc("bne_z0");
    cyc("t0"); cyc("t1");
    bus.IROut = 16'h1700;
    cyc("st_r4");
    cyc("t0"); cyc("t1");
    bus.IROut = 16'h0A00;
    cyc("inc_r3");
    cyc("t0"); cyc("t1");
    bus.IROut = 16'h1200;
    cyc("ld_r3");
    cyc("t0"); cyc("t1");
    bus.IROut = 16'h4000;
    cyc("nop");
    cyc("t0"); cyc("t1");

    // HALT parks the sequencer until Reset
    bus.IROut = 16'hFC00;
    cyc("halt_exec");
    bus.IROut = 16'h0D42;
    for (int i = 0; i < 10; i++) cyc("halted");
    Reset = 1'b0;
    cyc("halt_rst");
    Reset = 1'b1;
    cyc("init_after_halt");

    // Reset during the high-byte fetch abandons the instruction
    cyc("t0");
    Reset = 1'b0;
    cyc("rst_at_t1");
    Reset = 1'b1;
    cyc("init_after_t1_rst");

`ifdef SEQ_STALL_EN
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) cyc("stall_t0");
    Stall = 1'b0;
    cyc("t0_resume");
    Stall = 1'b1;
    Reset = 1'b0;
    cyc("rst_over_stall");
    Stall = 1'b0;
    Reset = 1'b1;
    cyc("init_after_stall_rst");
`endif

    // Randomized instruction stream with occasional reset and stall
    for (int i = 0; i < 600; i++) begin
      bus.IROut = {ops[$urandom_range(7)], 10'($urandom)};
      bus.Z     = 1'($urandom);
      Reset     = ($urandom_range(39) != 0) && !(phase == PH_HALT && $urandom_range(3) == 0);
`ifdef SEQ_STALL_EN
      Stall     = ($urandom_range(7) == 0);
`endif
      cyc("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the bench always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
